bit_unreorder: RTL and testbench
================================

// Module: bit_unreorder
// PURPOSE
//  Inverse of bit_reorder: restores original bit order of words permuted by
//  out[i] = in[BITi]. Computes out[BITi] = in[i] using a runtime-loadable map,
//  validated before use. Sits on the receive side of a reordered data stream,
//  with a valid/ready handshake and a 2-stage registered pipeline.
// PARAMETERS
//  DATA_WIDTH    32            word width in bits
//  IDX_WIDTH     5             bits per map entry; 2**IDX_WIDTH >= DATA_WIDTH
//  ARCHITECTURE  "BEHAVIORAL"  implementation selector; only BEHAVIORAL required
// PORTS
//  clk         in   1           single clock; all logic on rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  cfg_wr_en   in   1           write cfg_data into shadow map entry cfg_addr
//  cfg_addr    in   IDX_WIDTH   map index i, 0..DATA_WIDTH-1
//  cfg_data    in   IDX_WIDTH   BITi value: source position used by the forward reorder
//  cfg_commit  in   1           start validation of the shadow map
//  cfg_busy    out  1           high while validation runs
//  cfg_done    out  1           1-cycle pulse when validation ends
//  map_err     out  1           last validation failed; sticky until next commit
//  in_data     in   DATA_WIDTH  reordered word
//  in_valid    in   1           in_data valid
//  in_ready    out  1           block accepts a word this cycle
//  out_data    out  DATA_WIDTH  restored word
//  out_valid   out  1           out_data valid
//  out_ready   in   1           downstream accepts out_data
// BEHAVIOUR
//  Reset: active and shadow maps = identity (entry i = i); out_valid=0,
//   out_data=0, cfg_busy=0, cfg_done=0, map_err=0, pipeline empty, FSM=RUN.
//  Datapath: stage A registers in_data; stage B registers permute(A) using the
//   active map. Transfer occurs when valid&&ready. Stage ready = !valid ||
//   next_ready; in_ready = !vA || !vB || out_ready. Latency 2 cycles, one word
//   per cycle sustained, no loss/duplication under backpressure; out_data stable
//   while out_valid && !out_ready.
//  Map: cfg_wr_en in RUN writes shadow[cfg_addr]; cfg_addr >= DATA_WIDTH ignored.
//   Writes never affect the active map directly.
//  FSM RUN -> CHECK on cfg_commit (RUN only). cfg_busy=1 in CHECK/COMMIT.
//   CHECK: scans i = 0..DATA_WIDTH-1, one entry per cycle (DATA_WIDTH cycles);
//   sets a hit vector; fail if shadow[i] >= DATA_WIDTH or hit[shadow[i]] already set.
//   CHECK -> COMMIT after the last entry. COMMIT (1 cycle): on pass, active <= shadow
//   and map_err <= 0; on fail, active unchanged and map_err <= 1; cfg_done=1;
//   -> RUN. map_err is cleared to 0 at the commit that enters CHECK.
//  In CHECK/COMMIT, cfg_wr_en and cfg_commit are ignored (no queueing).
//  Datapath never stalls for configuration. The new map applies to words entering
//   stage B on the cycle after COMMIT; words already in B are unaffected.
//  Simultaneous cfg_wr_en and cfg_commit in RUN: the write lands, then CHECK
//   starts, and the write is included in validation.
//  rst_n low at any time, including mid-CHECK: immediate return to reset state;
//   any partial validation is discarded.
// TESTING
//  1 Reset, identity map: stream 0xF0F0F0F0, 0x12345678 with out_ready=1 ->
//    same words out 2 cycles later, in order.
//  2 Load BIT1..7 = 5,6,7,1,2,3,4 (others identity), commit -> cfg_busy for 33
//    cycles, cfg_done pulse, map_err=0; input 0xF0F0F08E -> output 0xF0F0F0F0.
//  3 Load duplicate (entries 1 and 2 both = 5), commit -> map_err=1; active map
//    unchanged: 0xF0F0F08E still restores to 0xF0F0F0F0 under the test-2 map.
//  4 Backpressure: continuous in_valid; out_ready=0 for 5 cycles -> in_ready
//    falls after 2 words held; no word lost, duplicated or reordered.
//  5 Assert rst_n=0 at cycle 10 of CHECK -> cfg_busy=0, map_err=0, no cfg_done
//    pulse, identity map active, out_valid=0.
//  6 cfg_wr_en/cfg_commit pulses during CHECK -> ignored; the result matches
//    the map as it stood at commit time.

Source files
------------

// File: rtl/bit_unreorder.sv
// Receive-side inverse bit permutation: out[map[i]] = in[i], with a shadow map
// that is validated as a true permutation before it replaces the active map.
module bit_unreorder #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned IDX_WIDTH    = 5,
   parameter              ARCHITECTURE = "BEHAVIORAL"
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_wr_en,
   input  logic [IDX_WIDTH-1:0]  cfg_addr,
   input  logic [IDX_WIDTH-1:0]  cfg_data,
   input  logic                  cfg_commit,
   output logic                  cfg_busy,
   output logic                  cfg_done,
   output logic                  map_err,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   generate
      if (ARCHITECTURE != "BEHAVIORAL") begin : g_arch_check
         $error("bit_unreorder: only the BEHAVIORAL architecture is implemented");
      end
      if ((64'd1 << IDX_WIDTH) < 64'(DATA_WIDTH)) begin : g_idx_check
         $error("bit_unreorder: IDX_WIDTH too small for DATA_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_CHECK  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t                state;
   logic [IDX_WIDTH-1:0]  shadow [DATA_WIDTH];
   logic [IDX_WIDTH-1:0]  active [DATA_WIDTH];
   logic [IDX_WIDTH-1:0]  scan_idx;
   logic [DATA_WIDTH-1:0] hit;
   logic                  fail_acc;

   logic [IDX_WIDTH-1:0]  scan_val;
   logic                  scan_oob;
   logic                  scan_bad;
   logic                  scan_last;

   // Validation of the shadow entry currently being scanned
   always_comb begin
      scan_val  = shadow[scan_idx];
      scan_oob  = 32'(scan_val) >= DATA_WIDTH;
      scan_bad  = scan_oob ? 1'b1 : hit[scan_val];
      scan_last = 32'(scan_idx) == (DATA_WIDTH - 32'd1);
   end

   // Configuration FSM: shadow writes in RUN, sequential permutation check, commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         scan_idx <= '0;
         hit      <= '0;
         fail_acc <= 1'b0;
         cfg_busy <= 1'b0;
         cfg_done <= 1'b0;
         map_err  <= 1'b0;
         for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            shadow[i] <= IDX_WIDTH'(i);
            active[i] <= IDX_WIDTH'(i);
         end
      end else begin
         cfg_done <= 1'b0;
         case (state)
            ST_RUN: begin
               if (cfg_wr_en && (32'(cfg_addr) < DATA_WIDTH)) begin
                  shadow[cfg_addr] <= cfg_data;
               end
               if (cfg_commit) begin
                  state    <= ST_CHECK;
                  cfg_busy <= 1'b1;
                  map_err  <= 1'b0;
                  scan_idx <= '0;
                  hit      <= '0;
                  fail_acc <= 1'b0;
               end
            end
            ST_CHECK: begin
               if (scan_bad) begin
                  fail_acc <= 1'b1;
               end else begin
                  hit[scan_val] <= 1'b1;
               end
               scan_idx <= scan_idx + IDX_WIDTH'(1);
               if (scan_last) begin
                  state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               if (!fail_acc) begin
                  for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                     active[i] <= shadow[i];
                  end
                  map_err <= 1'b0;
               end else begin
                  map_err <= 1'b1;
               end
               cfg_done <= 1'b1;
               cfg_busy <= 1'b0;
               state    <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   logic                  a_valid;
   logic [DATA_WIDTH-1:0] a_data;
   logic                  a_ready;
   logic                  b_ready;
   logic [DATA_WIDTH-1:0] perm;

   always_comb begin
      b_ready  = !out_valid || out_ready;
      a_ready  = !a_valid || b_ready;
      in_ready = a_ready;
   end

   // Inverse permutation of the stage-A word through the active map
   always_comb begin
      perm = '0;
      for (int i = 0; i < int'(DATA_WIDTH); i++) begin
         perm[active[i]] = a_data[i];
      end
   end

   // Two-stage elastic pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid   <= 1'b0;
         a_data    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (a_ready) begin
            a_valid <= in_valid;
            if (in_valid) begin
               a_data <= in_data;
            end
         end
         if (b_ready) begin
            out_valid <= a_valid;
            if (a_valid) begin
               out_data <= perm;
            end
         end
      end
   end

endmodule

// File: tb/tb_bit_unreorder.sv
// Self-checking bench for bit_unreorder: directed scenarios plus randomized
// maps and traffic against a permutation/scoreboard model.
module tb_bit_unreorder;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_wr_en, cfg_commit;
   logic [IW-1:0] cfg_addr, cfg_data;
   logic          cfg_busy, cfg_done, map_err;
   logic [DW-1:0] in_data, out_data;
   logic          in_valid, in_ready, out_valid, out_ready;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   int m_shadow [DW];
   int m_active [DW];
   logic [DW-1:0] q [$];

   bit            held_v = 1'b0;
   logic [DW-1:0] held_d;

   bit_unreorder #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .ARCHITECTURE("BEHAVIORAL")) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
      .map_err(map_err),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_perm(input logic [DW-1:0] w);
      logic [DW-1:0] r = '0;
      for (int i = 0; i < int'(DW); i++) r[m_active[i]] = w[i];
      return r;
   endfunction

   function automatic bit shadow_ok();
      bit seen [DW];
      for (int i = 0; i < int'(DW); i++) seen[i] = 1'b0;
      for (int i = 0; i < int'(DW); i++) begin
         if (m_shadow[i] >= int'(DW) || seen[m_shadow[i]]) return 1'b0;
         seen[m_shadow[i]] = 1'b1;
      end
      return 1'b1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < int'(DW); i++) begin
         m_shadow[i] = i;
         m_active[i] = i;
      end
   endfunction

   // Scoreboard: occupancy-based in_ready, in-order data, stall stability
   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         held_v <= 1'b0;
      end else begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
         if (q.size() == 0) chk("out_valid_empty", {31'd0, out_valid}, '0);
         if (held_v) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", out_data, held_d);
         end
         held_v <= out_valid && !out_ready;
         held_d <= out_data;
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_word", out_data, 'x);
            else chk("out_data", out_data, q.pop_front());
         end
         if (in_valid && in_ready) q.push_back(model_perm(in_data));
      end
   end

   always @(posedge clk) if (rst_n && cfg_done) done_cnt++;

   task automatic write_entry(input int a, input int d);
      @(negedge clk);
      cfg_wr_en = 1'b1;
      cfg_addr  = IW'(a);
      cfg_data  = IW'(d);
      m_shadow[a] = d;
   endtask

   task automatic load_map(input int p [DW], input int n);
      for (int i = 0; i < n; i++) write_entry(i, p[i]);
      @(negedge clk);
      cfg_wr_en = 1'b0;
   endtask

   task automatic do_commit(input bit noise, input bit with_wr, input int wa, input int wd);
      bit exp_ok;
      int busy_n = 0;
      int d0 = done_cnt;
      int guard = 0;
      @(negedge clk);
      cfg_commit = 1'b1;
      if (with_wr) begin
         cfg_wr_en = 1'b1;
         cfg_addr  = IW'(wa);
         cfg_data  = IW'(wd);
         m_shadow[wa] = wd;
      end
      exp_ok = shadow_ok();
      @(negedge clk);
      cfg_commit = 1'b0;
      cfg_wr_en  = 1'b0;
      chk("busy_start", {31'd0, cfg_busy}, 32'd1);
      chk("err_cleared", {31'd0, map_err}, '0);
      while (cfg_busy && guard < 100) begin
         busy_n++;
         guard++;
         if (noise) begin
            cfg_wr_en  = 1'($urandom_range(1, 0));
            cfg_addr   = IW'($urandom_range(31, 0));
            cfg_data   = IW'($urandom_range(31, 0));
            cfg_commit = 1'($urandom_range(1, 0));
         end
         @(negedge clk);
      end
      cfg_wr_en  = 1'b0;
      cfg_commit = 1'b0;
      chk("busy_cycles", 32'(busy_n), 32'd33);
      repeat (3) @(negedge clk);
      chk("done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("map_err", {31'd0, map_err}, {31'd0, !exp_ok});
      if (exp_ok) for (int i = 0; i < int'(DW); i++) m_active[i] = m_shadow[i];
   endtask

   // Single word with literal expectation through an idle pipeline
   task automatic send_check(input string name, input logic [DW-1:0] w, input logic [DW-1:0] exp);
      int guard = 0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = w;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      chk(name, out_data, exp);
   endtask

   task automatic drain();
      int guard = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("drained", 32'(q.size()), '0);
   endtask

   initial begin
      int p [DW];
      int acc;
      rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_data = '0;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_busy", {31'd0, cfg_busy}, '0);
      chk("rst_done", {31'd0, cfg_done}, '0);
      chk("rst_err", {31'd0, map_err}, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: identity map, latency 2
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 32'hF0F0F0F0;
      @(negedge clk);
      in_data = 32'h12345678;
      chk("t1_lat_valid", {31'd0, out_valid}, '0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("t1_w0", out_data, 32'hF0F0F0F0);
      @(negedge clk);
      chk("t1_w1", out_data, 32'h12345678);
      @(negedge clk);
      chk("t1_empty", {31'd0, out_valid}, '0);

      // 2: partial map
      for (int i = 0; i < int'(DW); i++) p[i] = i;
      p[1] = 5; p[2] = 6; p[3] = 7; p[4] = 1; p[5] = 2; p[6] = 3; p[7] = 4;
      load_map(p, DW);
      do_commit(1'b0, 1'b0, 0, 0);
      chk("t2_model_pin", model_perm(32'hF0F0F08E), 32'hF0F0F0F0);
      send_check("t2_restore", 32'hF0F0F08E, 32'hF0F0F0F0);

      // 3: duplicate entry is rejected, active map kept
      write_entry(2, 5);
      @(negedge clk); cfg_wr_en = 1'b0;
      do_commit(1'b0, 1'b0, 0, 0);
      chk("t3_err_lit", {31'd0, map_err}, 32'd1);
      send_check("t3_restore", 32'hF0F0F08E, 32'hF0F0F0F0);
      write_entry(2, 6);
      @(negedge clk); cfg_wr_en = 1'b0;

      // 4: backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = $urandom;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         if (in_ready) acc++;
         @(negedge clk);
         if (acc > 0 && c < 4) in_data = $urandom;
      end
      chk("t4_accepted", 32'(acc), 32'd2);
      chk("t4_in_ready_low", {31'd0, in_ready}, '0);
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         in_data = $urandom;
      end
      drain();

      // 6: noise during CHECK, simultaneous write+commit
      for (int i = 0; i < int'(DW); i++) p[i] = (i + 3) % int'(DW);
      load_map(p, DW - 1);
      do_commit(1'b1, 1'b1, DW - 1, (DW - 1 + 3) % DW);
      chk("t6_err", {31'd0, map_err}, '0);
      send_check("t6_restore", 32'h00000001, 32'h00000008);

      // 5: reset in the middle of CHECK
      for (int i = 0; i < int'(DW); i++) p[i] = int'(DW) - 1 - i;
      load_map(p, DW);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hA5A5A5A5;
      repeat (2) @(negedge clk);
      in_valid   = 1'b0;
      cfg_commit = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0;
      acc = done_cnt;
      repeat (9) @(negedge clk);
      chk("t5_busy_before", {31'd0, cfg_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_busy", {31'd0, cfg_busy}, '0);
      chk("t5_err", {31'd0, map_err}, '0);
      chk("t5_out_valid", {31'd0, out_valid}, '0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("t5_no_done", 32'(done_cnt - acc), '0);
      chk("t5_busy_idle", {31'd0, cfg_busy}, '0);
      send_check("t5_identity", 32'hF0F0F08E, 32'hF0F0F08E);

      // Randomized maps and traffic
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < int'(DW); i++) p[i] = i;
         for (int i = int'(DW) - 1; i > 0; i--) begin
            int j = int'($urandom_range(i, 0));
            int t = p[i];
            p[i] = p[j];
            p[j] = t;
         end
         if ($urandom_range(2, 0) == 0) p[$urandom_range(15, 0)] = p[$urandom_range(31, 16)];
         load_map(p, DW);
         do_commit(r[0], 1'b0, 0, 0);
         for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(3, 0) != 0);
            in_data   = $urandom;
            out_ready = 1'($urandom_range(2, 0) != 0);
         end
         @(negedge clk);
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
